// File: rtl/reflet_float_add_arbiter.sv
// Round-robin arbiter sharing one single-precision float adder between nreq requesters.
// Contains the adder (reflet_float_add) and the arbiter top (reflet_float_add_arbiter).

module reflet_float_add (
  input  logic [31:0] i_in1,
  input  logic [31:0] i_in2,
  input  logic        i_enable_add,
  input  logic        i_enable_sub,
  output logic [31:0] o_sum
);
  logic              w_sb;
  logic              w_swap;
  logic [31:0]       w_big;
  logic [31:0]       w_small;
  logic [26:0]       w_ma;
  logic [26:0]       w_mb;
  logic [26:0]       w_mb_al;
  logic [7:0]        w_d;
  logic [27:0]       w_s;
  logic [26:0]       w_n;
  logic [4:0]        w_lz;
  logic signed [9:0] w_e;
  logic [24:0]       w_m;
  logic [22:0]       w_frac;
  logic              w_up;

  // Denormal inputs are treated as zero and underflowing results flush to +0.
  always_comb begin
    w_sb    = i_in2[31] ^ i_enable_sub;
    w_swap  = i_in2[30:0] > i_in1[30:0];
    w_big   = w_swap ? {w_sb, i_in2[30:0]} : i_in1;
    w_small = w_swap ? i_in1 : {w_sb, i_in2[30:0]};
    w_ma    = (w_big[30:23] != 8'd0) ? {1'b1, w_big[22:0], 3'b000} : 27'd0;
    w_mb    = (w_small[30:23] != 8'd0) ? {1'b1, w_small[22:0], 3'b000} : 27'd0;
    w_d     = w_big[30:23] - w_small[30:23];
    if (w_d >= 8'd27) w_mb_al = {26'd0, |w_mb};
    else w_mb_al = (w_mb >> w_d) | {26'd0, |(w_mb & ~({27{1'b1}} << w_d))};
    w_s = (w_big[31] == w_small[31]) ? ({1'b0, w_ma} + {1'b0, w_mb_al})
                                     : ({1'b0, w_ma} - {1'b0, w_mb_al});
    w_lz = 5'd0;
    for (int i = 0; i < 27; i++) if (w_s[i]) w_lz = 5'(26 - i);
    if (w_s[27]) begin
      w_n = {w_s[27:2], w_s[1] | w_s[0]};
      w_e = $signed({2'b00, w_big[30:23]}) + 10'sd1;
    end else begin
      w_n = w_s[26:0] << w_lz;
      w_e = $signed({2'b00, w_big[30:23]}) - $signed({5'd0, w_lz});
    end
    // Round to nearest, ties to even, on guard/round/sticky bits.
    w_up = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_m  = {1'b0, w_n[26:3]} + {24'd0, w_up};
    if (w_m[24]) w_e = w_e + 10'sd1;
    w_frac = w_m[24] ? w_m[23:1] : w_m[22:0];
    if (!(i_enable_add | i_enable_sub) || (w_s == 28'd0) || (w_e <= 10'sd0)) o_sum = 32'd0;
    else if (w_e >= 10'sd255) o_sum = {w_big[31], 8'hFF, 23'd0};
    else o_sum = {w_big[31], w_e[7:0], w_frac};
  end
endmodule

module reflet_float_add_arbiter #(
  parameter int nreq    = 4,
  parameter int id_size = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [nreq-1:0]      req,
  input  logic [nreq-1:0]      op_sub,
  input  logic [32*nreq-1:0]   in1,
  input  logic [32*nreq-1:0]   in2,
  output logic [nreq-1:0]      grant,
  output logic [31:0]          result,
  output logic [id_size-1:0]   result_id,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [1:0]           dbg_state
);
  // Handshake: result is consumed at a rising edge where result_valid && result_ready;
  // result/result_id stay stable while result_valid is high and result_ready is low.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  logic [1:0]         r_state;
  logic [id_size-1:0] r_ptr;
  logic [id_size-1:0] r_id;
  logic [31:0]        r_op1;
  logic [31:0]        r_op2;
  logic               r_op_sub;
  logic [id_size-1:0] w_winner;
  logic               w_found;
  logic [nreq-1:0]    w_onehot;
  logic               w_capture;
  logic [31:0]        w_sum;

  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < nreq; i++) begin
      int idx;
      idx = int'(r_ptr) + i;
      if (idx >= nreq) idx = idx - nreq;
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = idx[id_size-1:0];
      end
    end
    w_onehot[w_winner] = 1'b1;
  end

  assign w_capture = w_found && ((r_state == IDLE) || ((r_state == VALID) && result_ready));
  assign dbg_state = r_state;

  reflet_float_add u_add (
    .i_in1        (r_op1),
    .i_in2        (r_op2),
    .i_enable_add (~r_op_sub),
    .i_enable_sub (r_op_sub),
    .o_sum        (w_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_op_sub     <= 1'b0;
      grant        <= '0;
      result       <= '0;
      result_id    <= '0;
      result_valid <= 1'b0;
    end else begin
      grant <= '0;
      case (r_state)
        IDLE: if (w_capture) r_state <= CALC;
        CALC: begin
          result       <= w_sum;
          result_id    <= r_id;
          result_valid <= 1'b1;
          r_state      <= VALID;
        end
        VALID: if (result_ready) begin
          result_valid <= 1'b0;
          r_state      <= w_capture ? CALC : IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_capture) begin
        r_op1    <= in1[32*w_winner +: 32];
        r_op2    <= in2[32*w_winner +: 32];
        r_op_sub <= op_sub[w_winner];
        r_id     <= w_winner;
        grant    <= w_onehot;
        r_ptr    <= (int'(w_winner) == nreq - 1) ? '0 : w_winner + 1'b1;
      end
    end
  end
endmodule
